// File: rtl/key_entry_fsm_pkg.sv
// rtl/key_entry_fsm_pkg.sv - key codes, operator codes, states and helpers shared by key entry and calculate
package key_entry_fsm_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BUF_W      = 31;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_MUL  = 4'hC;
  localparam logic [3:0] KEY_DIV  = 4'hD;
  localparam logic [3:0] KEY_EQ   = 4'hE;
  localparam logic [3:0] KEY_NONE = 4'hF;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_NONE = 3'd7;

  typedef enum logic [2:0] {
    S_OP1,
    S_OPR,
    S_OP2,
    S_WAIT,
    S_RES
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  function automatic logic [2:0] key_to_op(input logic [3:0] k);
    logic [3:0] d;
    d = k - KEY_ADD;
    return d[2:0];
  endfunction

  // Negating {0, magnitude} maps a signed zero onto plain 0.
  function automatic logic [31:0] apply_sign(input logic neg, input logic [BUF_W-1:0] mag);
    logic [31:0] v;
    v = {1'b0, mag};
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/key_entry_fsm_key_edge_detect.sv
// rtl/key_entry_fsm_key_edge_detect.sv - turns the eBCD key level into a one-cycle press plus registered code
module key_edge_detect
  import key_entry_fsm_pkg::*;
(
  input  logic       sw_clk,
  input  logic       rst,
  input  logic [3:0] eBCD,
  output logic       press,
  output logic [3:0] key
);

  logic [3:0] prev_key;

  // A press needs an idle (F) level first, so key-to-key slides never fire.
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      prev_key <= KEY_NONE;
      press    <= 1'b0;
      key      <= KEY_NONE;
    end else begin
      prev_key <= eBCD;
      press    <= (prev_key == KEY_NONE) && (eBCD != KEY_NONE);
      key      <= eBCD;
    end
  end

endmodule

// File: rtl/key_entry_fsm.sv
// rtl/key_entry_fsm.sv - operand/operator entry FSM feeding calculate; KEY_ENTRY_CHAIN_EN chains operators in S_OP2
module key_entry_fsm
  import key_entry_fsm_pkg::*;
#(
  parameter int MAX_DIGITS = 9,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CALC_LAT   = 1
) (
  input  logic              sw_clk,
  input  logic              rst,
  input  logic [3:0]        eBCD,
  input  logic [DATA_W-1:0] ans,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [2:0]        operator,
  output logic              calc_start,
  output logic [DATA_W-1:0] fnd_serial,
  output logic              digit_full
);

  localparam logic [3:0] MAX_CNT  = 4'(MAX_DIGITS);
  localparam logic [7:0] WAIT_END = 8'(CALC_LAT);

  logic             press;
  logic [3:0]       key;
  state_t           state;
  logic [BUF_W-1:0] buffer;
  logic             sign_bit;
  logic [3:0]       count;
  logic [DATA_W-1:0] result;
  logic [7:0]       wait_cnt;
`ifdef KEY_ENTRY_CHAIN_EN
  logic             chain_pend;
  logic [2:0]       pend_op;
`endif

  logic [BUF_W-1:0]  buf_acc;
  logic              acc_ok;
  logic [DATA_W-1:0] buf_val;

  key_edge_detect u_edge (
    .sw_clk (sw_clk),
    .rst    (rst),
    .eBCD   (eBCD),
    .press  (press),
    .key    (key)
  );

  // Leading zeros neither grow the buffer nor count as digits.
  assign buf_acc = buffer * 31'd10 + {27'd0, key};
  assign acc_ok  = (count < MAX_CNT) && !((buffer == '0) && (key == 4'd0));
  assign buf_val = DATA_W'(apply_sign(sign_bit, buffer));

  always_ff @(posedge sw_clk) begin
    if (rst) begin
      state      <= S_OP1;
      buffer     <= '0;
      sign_bit   <= 1'b0;
      count      <= '0;
      result     <= '0;
      wait_cnt   <= '0;
      operand1   <= '0;
      operand2   <= '0;
      operator   <= OP_NONE;
      calc_start <= 1'b0;
      fnd_serial <= '0;
      digit_full <= 1'b0;
`ifdef KEY_ENTRY_CHAIN_EN
      chain_pend <= 1'b0;
      pend_op    <= OP_NONE;
`endif
    end else begin
      calc_start <= 1'b0;
      case (state)
        S_OP1: begin
          if (press) begin
            if (is_digit(key)) begin
              if (acc_ok) begin
                buffer <= buf_acc;
                count  <= count + 4'd1;
              end
            end else if ((key == KEY_SUB) && (count == '0)) begin
              sign_bit <= ~sign_bit;
            end else if (is_op(key)) begin
              operand1 <= buf_val;
              operator <= key_to_op(key);
              buffer   <= '0;
              count    <= '0;
              sign_bit <= 1'b0;
              state    <= S_OPR;
            end
          end
        end
        S_OPR: begin
          if (press) begin
            if (is_digit(key)) begin
              if (acc_ok) begin
                buffer <= buf_acc;
                count  <= count + 4'd1;
              end
              state <= S_OP2;
            end else if (key == KEY_SUB) begin
              sign_bit <= ~sign_bit;
            end else if (is_op(key)) begin
              operator <= key_to_op(key);
            end
          end
        end
        S_OP2: begin
          if (press) begin
            if (is_digit(key)) begin
              if (acc_ok) begin
                buffer <= buf_acc;
                count  <= count + 4'd1;
              end
            end else if (key == KEY_EQ) begin
              operand2   <= buf_val;
              calc_start <= 1'b1;
              buffer     <= '0;
              count      <= '0;
              sign_bit   <= 1'b0;
              wait_cnt   <= '0;
              state      <= S_WAIT;
`ifdef KEY_ENTRY_CHAIN_EN
            end else if (is_op(key)) begin
              operand2   <= buf_val;
              calc_start <= 1'b1;
              buffer     <= '0;
              count      <= '0;
              sign_bit   <= 1'b0;
              wait_cnt   <= '0;
              chain_pend <= 1'b1;
              pend_op    <= key_to_op(key);
              state      <= S_WAIT;
`endif
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_END) begin
            result <= ans;
            state  <= S_RES;
`ifdef KEY_ENTRY_CHAIN_EN
            if (chain_pend) begin
              operand1   <= ans;
              operator   <= pend_op;
              chain_pend <= 1'b0;
              state      <= S_OPR;
            end
`endif
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RES: begin
          if (press) begin
            if (is_digit(key)) begin
              operand1 <= '0;
              operand2 <= '0;
              operator <= OP_NONE;
              sign_bit <= 1'b0;
              buffer   <= {27'd0, key};
              count    <= (key != 4'd0) ? 4'd1 : 4'd0;
              state    <= S_OP1;
            end else if (is_op(key)) begin
              operand1 <= result;
              operator <= key_to_op(key);
              buffer   <= '0;
              count    <= '0;
              sign_bit <= 1'b0;
              state    <= S_OPR;
            end
          end
        end
        default: state <= S_OP1;
      endcase

      // Display and full flag follow the state registered on the previous edge.
      case (state)
        S_OP1, S_OP2: fnd_serial <= buf_val;
        S_OPR:        fnd_serial <= operand1;
        default:      fnd_serial <= result;
      endcase
      digit_full <= (count == MAX_CNT);
    end
  end

endmodule
